poly_pitch_generator: RTL

Multi-channel successor to the single-voice pitch generator: converts per-channel note/octave commands into independent square waves and an optional mixed amplitude sample. It sits between the melody sequencer, which issues commands, and the audio output stage, which consumes `wave` bits or `sample`. Each channel has its own half-period counter, gate and volume. Pitch is derived arithmetically from a shared base-period table, so there is no per-octave ROM.

---
 rtl/pitch_pkg.sv | 47 ++++
 rtl/pitch_voice.sv | 62 ++++++
 rtl/poly_pitch_generator.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pitch_pkg.sv
// Shared pitch constants: the octave-0 half-period table at 100 MHz and the
// shift-and-clamp rule that turns a note/octave pair into a half-period.
package pitch_pkg;

    localparam int CLK_HZ        = 100_000_000;
    localparam int NOTE_REST_MIN = 12;
    localparam int HALF_W        = 24;

    typedef enum logic [3:0] {
        NOTE_C    = 4'd0,
        NOTE_CS   = 4'd1,
        NOTE_D    = 4'd2,
        NOTE_DS   = 4'd3,
        NOTE_E    = 4'd4,
        NOTE_F    = 4'd5,
        NOTE_FS   = 4'd6,
        NOTE_G    = 4'd7,
        NOTE_GS   = 4'd8,
        NOTE_A    = 4'd9,
        NOTE_AS   = 4'd10,
        NOTE_B    = 4'd11,
        NOTE_REST = 4'd12
    } note_e;

    localparam logic [HALF_W-1:0] BASE_HALF [0:11] = '{
        24'd3_057_805, 24'd2_886_150, 24'd2_724_125, 24'd2_571_223,
        24'd2_426_848, 24'd2_290_627, 24'd2_162_063, 24'd2_040_678,
        24'd1_926_166, 24'd1_818_182, 24'd1_716_124, 24'd1_619_790
    };

    // Octave is one bit wider than the command field so the clamp can be
    // exercised directly; rest notes map to the clamp value.
    function automatic logic [HALF_W-1:0] half_period(input logic [3:0] note,
                                                      input logic [4:0] octave);
        logic [HALF_W-1:0] half;
        half = '0;
        if (note < 4'(NOTE_REST_MIN)) begin
            half = BASE_HALF[note];
        end
        half = half >> octave;
        if (half < HALF_W'(2)) begin
            half = HALF_W'(2);
        end
        return half;
    endfunction

endpackage

// File: rtl/pitch_voice.sv
// One voice: gate, half-period counter and square-wave register.
// Latency: an update lands at the next edge; wave is a flop output.
// Backpressure: none, every update is taken immediately.
module pitch_voice #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                upd_vld,
    input  logic                upd_rest,
    input  logic [PERIOD_W-1:0] upd_half,
    output logic                wave
);

    logic                gate_q, gate_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic                wave_q, wave_d;

    always_comb begin
        gate_d = gate_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        wave_d = wave_q;
        if (upd_vld) begin
            // Any command restarts the phase; a rest freezes the counter at 0.
            cnt_d = '0;
            if (upd_rest) begin
                gate_d = 1'b0;
                wave_d = 1'b0;
            end else begin
                gate_d = 1'b1;
                wave_d = 1'b1;
                half_d = upd_half;
            end
        end else if (gate_q) begin
            if (cnt_q == half_q - PERIOD_W'(1)) begin
                cnt_d  = '0;
                wave_d = ~wave_q;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_q <= 1'b0;
            cnt_q  <= '0;
            half_q <= '0;
            wave_q <= 1'b0;
        end else begin
            gate_q <= gate_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/poly_pitch_generator.sv
// Polyphonic square-wave generator with optional volume mixer (POLY_PITCH_MIX_EN).
// Latency: command accepted in cycle N drives wave from cycle N+2; sample trails wave by one cycle.
// Backpressure: none; cmd_ready is low only while rst_n is low.
module poly_pitch_generator
    import pitch_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int PERIOD_W = 24,
    parameter  int VOL_W    = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int SAMPLE_W = VOL_W + $clog2(CHANNELS) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CH_W-1:0]     cmd_channel,
    input  logic [3:0]          cmd_note,
    input  logic [3:0]          cmd_octave,
    input  logic [VOL_W-1:0]    cmd_volume,
    output logic [CHANNELS-1:0] wave,
    output logic [SAMPLE_W-1:0] sample
);

    logic            cmd_acc;
    logic            s1_vld_q, s1_vld_d;
    logic [CH_W-1:0] s1_ch_q, s1_ch_d;
    logic [3:0]      s1_note_q, s1_note_d;
    logic [3:0]      s1_oct_q, s1_oct_d;

    assign cmd_ready = rst_n;
    assign cmd_acc   = cmd_valid && cmd_ready;

    always_comb begin
        s1_vld_d  = cmd_acc;
        s1_ch_d   = s1_ch_q;
        s1_note_d = s1_note_q;
        s1_oct_d  = s1_oct_q;
        if (cmd_acc) begin
            s1_ch_d   = cmd_channel;
            s1_note_d = cmd_note;
            s1_oct_d  = cmd_octave;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_note_q <= '0;
            s1_oct_q  <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_ch_q   <= s1_ch_d;
            s1_note_q <= s1_note_d;
            s1_oct_q  <= s1_oct_d;
        end
    end

    logic [HALF_W-1:0]   s2_half_full;
    logic [PERIOD_W-1:0] s2_half;
    logic                s2_rest;
    logic [CHANNELS-1:0] upd_vld;

    assign s2_half_full = half_period(s1_note_q, {1'b0, s1_oct_q});
    assign s2_half      = PERIOD_W'(s2_half_full);
    assign s2_rest      = (s1_note_q >= 4'(NOTE_REST_MIN));

    // A channel index beyond CHANNELS matches no voice, so it is dropped here.
    always_comb begin
        upd_vld = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            upd_vld[i] = s1_vld_q && (s1_ch_q == CH_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_voice
        pitch_voice #(
            .PERIOD_W (PERIOD_W)
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .upd_vld  (upd_vld[g]),
            .upd_rest (s2_rest),
            .upd_half (s2_half),
            .wave     (wave[g])
        );
    end

`ifdef POLY_PITCH_MIX_EN
    logic [VOL_W-1:0]    s1_vol_q, s1_vol_d;
    logic [VOL_W-1:0]    vol_q [CHANNELS];
    logic [VOL_W-1:0]    vol_d [CHANNELS];
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    // Volume is captured alongside the wave update so sample sees both together.
    always_comb begin
        s1_vol_d = cmd_acc ? cmd_volume : s1_vol_q;
        sample_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            vol_d[i] = (upd_vld[i] && !s2_rest) ? s1_vol_q : vol_q[i];
            if (wave[i]) begin
                sample_d = sample_d + SAMPLE_W'(vol_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vol_q <= '0;
            sample_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                vol_q[i] <= '0;
            end
        end else begin
            s1_vol_q <= s1_vol_d;
            sample_q <= sample_d;
            for (int i = 0; i < CHANNELS; i++) begin
                vol_q[i] <= vol_d[i];
            end
        end
    end

    assign sample = sample_q;
`else
    logic unused_vol;
    assign unused_vol = ^cmd_volume;
    assign sample     = '0;
`endif

endmodule
